// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Round-robin arbiter/sequencer that shares one single-port
//               memory between NUM_REQ requesters. Each accepted command
//               becomes exactly one one-cycle read or write strobe, followed
//               by a one-cycle response pulse to the requester that issued it.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic                       busy,
    output logic [ADDR_W-1:0]          mem_address,
    output logic                       mem_write,
    output logic                       mem_read,
    output logic [DATA_W-1:0]          mem_data_in,
    input  logic [DATA_W-1:0]          mem_data_out
);

    localparam int c_GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_RESP  = 2'd3;

    // Highest index so that requester 0 wins the first arbitration after reset.
    localparam logic [c_GW-1:0] c_LAST_INIT = c_GW'(NUM_REQ - 1);

    logic [1:0]         r_state;
    logic [c_GW-1:0]    r_last_grant;
    logic [c_GW-1:0]    r_grant_id;
    logic               r_op_write;
    logic [c_GW-1:0]    w_winner;
    logic               w_found;
    logic [NUM_REQ-1:0] w_ready;
    logic               w_accept;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        int idx;
        w_found  = 1'b0;
        w_winner = '0;
        idx      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(r_last_grant) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!w_found && req_valid[idx[c_GW-1:0]]) begin
                w_found  = 1'b1;
                w_winner = idx[c_GW-1:0];
            end
        end
    end

    // One-hot grant, only offered while idle; held low during reset so all
    // outputs read zero as soon as reset rises.
    always_comb begin
        w_ready = '0;
        if ((r_state == c_IDLE) && w_found && !reset) begin
            w_ready[w_winner] = 1'b1;
        end
    end

    assign req_ready = w_ready;
    // The grant always targets a valid requester, so a grant is an acceptance.
    assign w_accept  = |w_ready;

    // Sequencer: accept, strobe memory for one cycle, capture read data, respond.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= c_IDLE;
            r_last_grant <= c_LAST_INIT;
            r_grant_id   <= '0;
            r_op_write   <= 1'b0;
            rsp_valid    <= '0;
            rsp_rdata    <= '0;
            busy         <= 1'b0;
            mem_address  <= '0;
            mem_write    <= 1'b0;
            mem_read     <= 1'b0;
            mem_data_in  <= '0;
        end else begin
            // Strobes and response are single-cycle pulses by default.
            mem_write <= 1'b0;
            mem_read  <= 1'b0;
            rsp_valid <= '0;
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        mem_address  <= req_addr[w_winner*ADDR_W +: ADDR_W];
                        mem_data_in  <= req_wdata[w_winner*DATA_W +: DATA_W];
                        r_op_write   <= req_write[w_winner];
                        mem_write    <= req_write[w_winner];
                        mem_read     <= !req_write[w_winner];
                        r_grant_id   <= w_winner;
                        r_last_grant <= w_winner;
                        busy         <= 1'b1;
                        r_state      <= c_ISSUE;
                    end
                end
                c_ISSUE: begin
                    if (r_op_write) begin
                        rsp_valid[r_grant_id] <= 1'b1;
                        r_state               <= c_RESP;
                    end else begin
                        r_state <= c_WAIT;
                    end
                end
                c_WAIT: begin
                    // Memory presents read data during this cycle.
                    rsp_rdata             <= mem_data_out;
                    rsp_valid[r_grant_id] <= 1'b1;
                    r_state               <= c_RESP;
                end
                c_RESP: begin
                    busy    <= 1'b0;
                    r_state <= c_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter and sequencer that shares the single-port 8-entry x 8-bit `memory` block between NUM_REQ independent requesters. Each requester issues read or write commands through a valid/ready handshake and receives a one-cycle response pulse. The block owns the memory's `address`/`write`/`read`/`data_in` pins, and it guarantees one memory operation at a time with strictly one-cycle `read`/`write` strobes.

## Interface
- NUM_REQ, 2: number of requesters, legal range 2..4
- ADDR_W, 3: memory address width
- DATA_W, 8: memory data width
- clock  in  1  rising-edge clock shared with `memory`
- reset  in  1  asynchronous, active-high; shared with `memory`
- req_valid  in  NUM_REQ  per-requester command valid
- req_write  in  NUM_REQ  per-requester command type: 1 = write, 0 = read
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  packed write data, same packing scheme
- req_ready  out  NUM_REQ  one-hot grant; combinational, asserted only in IDLE
- rsp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse to the granted requester
- rsp_rdata  out  DATA_W  read data, registered; valid while rsp_valid is high for a read
- busy  out  1  high whenever the state is not IDLE (registered)
- mem_address  out  ADDR_W  drives memory `address` (registered)
- mem_write  out  1  drives memory `write` (registered)
- mem_read  out  1  drives memory `read` (registered)
- mem_data_in  out  DATA_W  drives memory `data_in` (registered)
- mem_data_out  in  DATA_W  from memory `data_out`

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If any req_valid is high, select the winner round-robin.
  - The search starts at last_grant+1, wraps modulo NUM_REQ, and takes the first requester with valid set.
  - Assert req_ready for the winner only. Acceptance is the cycle where req_valid and req_ready are both high.
  - On acceptance, register the following and go to ISSUE:
    - mem_address = winner's addr
    - mem_data_in = winner's wdata
    - the op type
    - grant_id = winner index
    - last_grant = winner index
  - If no req_valid is high, stay in IDLE with all strobes low.
- **ISSUE**
  - mem_write = op, mem_read = !op, each high for exactly this cycle.
  - Write: go to RESP.
  - Read: go to WAIT.
- **WAIT** (read only)
  - mem_data_out is valid this cycle; capture it into rsp_rdata at the closing edge.
  - Go to RESP.
- **RESP**
  - rsp_valid[grant_id] = 1 for exactly one cycle.
  - For a write, rsp_rdata holds its previous value.
  - Go to IDLE.
- req_ready is never asserted outside IDLE, so requesters must hold valid, write, addr and wdata stable until accepted.
- Round-robin guarantees that a continuously-valid requester is accepted within NUM_REQ grants.
- A requester dropping valid before acceptance is legal; it is simply not granted.
- Unused mem_address and mem_data_in retain their last values; only the strobes matter.
- **Reset**, asynchronous and taking priority:
  - state = IDLE, last_grant = NUM_REQ-1 (requester 0 wins first), grant_id = 0.
  - All outputs 0: req_ready, rsp_valid, rsp_rdata, busy, mem_address, mem_write, mem_read, mem_data_in.
  - Any in-flight transaction is dropped and produces no rsp_valid.
  - Because the memory shares this reset, its contents are also cleared to 0.

## Timing
- Accept-to-response latency: read 3 cycles (accept in T, rsp_valid in T+3); write 2 cycles (rsp_valid in T+2).
- Throughput: one read per 4 cycles, or one write per 3 cycles. The next acceptance is possible in the cycle after RESP.
- Memory strobes (mem_write, mem_read) are high for exactly one cycle per transaction and are never high together.
- Simultaneous valids:
  - Exactly one grant per IDLE cycle.
  - Losers see req_ready = 0 and are served in round-robin order on later IDLE cycles.
- Read-after-write to the same address from different requesters returns the new data, because operations are serialized.
- busy rises in the cycle after acceptance and falls in the cycle after RESP.

## Test plan
- **Reset values:** assert reset mid-stream -> all outputs 0 within the same cycle (asynchronous); first grant after release goes to requester 0.
- **Single write then read:** req0 writes 0xA5 to addr 3.
  - Write: rsp_valid[0] at T+2, with exactly one mem_write pulse carrying address 3 and data 0xA5.
  - Read back addr 3: rsp_valid[0] at T+3 with rsp_rdata = 0xA5.
- **Contention:** req0 and req1 both hold valid continuously (reads of addr 0 and addr 1) -> grants alternate 0,1,0,1; no requester is granted twice in a row; each rsp_valid goes only to the matching index.
- **Cross-requester coherency:** req1 writes 0x3C to addr 7 while req0 is waiting with a read of addr 7 -> if req1 is granted first, req0's rsp_rdata = 0x3C.
- **Reset mid-read:** assert reset during WAIT -> no rsp_valid pulse; state IDLE; a subsequent read of any address returns 0x00.
- **Wrap-around and priority (NUM_REQ=4):** set last_grant to 3; requesters 1 and 2 are valid -> requester 1 is granted first, then requester 2; with only requester 3 valid, it is granted on the first IDLE cycle.
